axi4_slave_mem: RTL and testbench
=================================

Name: axi4_slave_mem

Overview:
Synthesizable AXI4 (full) slave with an internal byte-addressable memory. It is the responder end of the AXI4 verification fabric: masters issue single-beat or burst writes and reads, and the block stores and returns data with AXI4-compliant handshakes. It handles one outstanding write and one outstanding read at a time; the write and read paths run independently.

Parameters:
- DATA_BYTES, 4: data bus width in bytes (power of 2, 1..128).
- ADDR_BYTES, 1: address width in bytes; memory spans 2^(8*ADDR_BYTES) bytes.
- NUM_ID_BITS, 4: width of the AXI ID fields.
- NUM_USER_BITS, 4: width of the AXI USER fields.

Ports:
- aclk, input, 1: clock; all logic on the rising edge.
- aresetn, input, 1: asynchronous active-low reset.
- awvalid in 1, awready out 1, awaddr in 8*ADDR_BYTES, awlen in 8, awsize in 3, awburst in 2, awid in NUM_ID_BITS, awuser in NUM_USER_BITS: write address channel.
- awlock in 1, awcache in 4, awprot in 3, awqos in 4, awregion in 4: accepted and ignored.
- wvalid in 1, wready out 1, wdata in 8*DATA_BYTES, wstrb in DATA_BYTES, wlast in 1, wuser in NUM_USER_BITS: write data channel; wuser is ignored.
- bvalid out 1, bready in 1, bresp out 2, bid out NUM_ID_BITS, buser out NUM_USER_BITS: write response channel.
- arvalid in 1, arready out 1, araddr in 8*ADDR_BYTES, arlen in 8, arsize in 3, arburst in 2, arid in NUM_ID_BITS, aruser in NUM_USER_BITS: read address channel.
- arlock, arcache, arprot, arqos, arregion: inputs, same widths as the AW equivalents; ignored.
- rvalid out 1, rready in 1, rdata out 8*DATA_BYTES, rresp out 2, rlast out 1, rid out NUM_ID_BITS, ruser out NUM_USER_BITS: read data channel.

Behaviour:
- Reset (async assert, sync release):
  - All outputs go to 0 except awready=1 and arready=1.
  - Memory is cleared to 0; both state machines return to IDLE.
  - Reset mid-burst abandons the transaction; no response is issued.
- Write FSM, states W_IDLE, W_DATA, W_RESP:
  - W_IDLE: awready=1, wready=0. On awvalid&&awready, latch addr/len/size/burst/id/user, clear the beat count, go to W_DATA.
  - W_DATA: awready=0, wready=1. On each wvalid&&wready, write each byte lane whose wstrb bit is 1 into the word at the current address aligned down to DATA_BYTES. Then advance the address and count.
  - After beat awlen+1 is accepted, go to W_RESP. bvalid=1 from the next cycle; bid=latched awid, buser=latched awuser.
  - W_RESP: hold bvalid and its fields stable until bready; then return to W_IDLE with awready=1 on the following cycle.
- Read FSM, states R_IDLE, R_DATA:
  - R_IDLE: arready=1. On arvalid&&arready, latch the request and go to R_DATA.
  - R_DATA: rvalid=1 beginning the cycle after the AR handshake. rdata = memory word at the aligned current address; rid/ruser = latched values; rlast=1 only on beat arlen+1.
  - Each rvalid&&rready advances the beat. rdata/rlast/rid/ruser/rresp stay stable while rvalid=1 and rready=0.
  - After the last beat: rvalid=0 and return to R_IDLE.
- Address update per beat, with step = 2^size:
  - FIXED (00): address unchanged.
  - INCR (01): address + step, modulo 2^(8*ADDR_BYTES).
  - WRAP (10): address + step, wrapping within an aligned window of (len+1)*step bytes.
- Responses:
  - bresp and rresp are OKAY (00) by default.
  - SLVERR (10) applies when any of the following holds:
    - burst type is 11 (reserved);
    - size > log2(DATA_BYTES);
    - WRAP with len not in {1,3,7,15}.
  - On a SLVERR request, no memory writes occur, but the full beat count is still accepted or returned. Read data on SLVERR beats is 0.
  - Write bursts where wlast does not match beat awlen+1 (early or missing): data is still written and bresp=SLVERR.
- Unaligned addresses: data access uses the address aligned down to DATA_BYTES; only wstrb selects the written lanes.
- Simultaneous write and read of the same word in one cycle: the read returns the old data; the new data is visible from the next cycle.
- Write and read FSMs run concurrently and do not block each other.

Test Plan:
- Reset: hold aresetn=0 for 100 ns -> awready=1, arready=1, all valids 0; a read of any address returns 0.
- Write INCR burst: awaddr=0, awburst=01, awsize=2, awlen=9, awid=0, 10 random words, wlast on beat 10 -> wready stays high for 10 beats; exactly one bvalid with bresp=00, bid=0. A read of 0 with arlen=9 returns the 10 words in order, rlast only on beat 10.
- Single read at araddr=0xFF (size 2, len 0) after that write -> one beat, rdata=word 63=0, rlast=1, rresp=00, rid=arid.
- Backpressure: hold bready=0 for 5 cycles, and hold rready=0 mid-burst -> bvalid/bresp and rdata/rlast stay stable; no beat is lost or duplicated.
- WRAP: addr=0x08, len=3, size=2, write A,B,C,D -> words 0x08,0x0C,0x00,0x04 hold A,B,C,D. A FIXED read at 0x04 with len=1 returns D twice.
- Errors: wstrb=0011 writes only the low 2 bytes. awburst=11 -> bresp=10 and memory unchanged. wlast on beat 2 of a len=3 burst -> bresp=10.

Source files
------------

// File: rtl/axi4_slave_mem.sv
// ---------------------------------------------------------------------------
// axi4_slave_mem
//
// AXI4 (full) slave backed by an internal byte-addressable memory that spans
// the whole address space. One write and one read transaction may be in
// flight at a time. The write and read paths are independent state machines
// that share only the storage array.
//
// Parameters
//   DATA_BYTES    : data bus width in bytes (power of 2, 1..128)
//   ADDR_BYTES    : address width in bytes; memory holds 2^(8*ADDR_BYTES) bytes
//   NUM_ID_BITS   : width of the AXI ID fields
//   NUM_USER_BITS : width of the AXI USER fields
//
// Ports
//   aclk, aresetn                     : clock, asynchronous active-low reset
//   aw*  (valid/ready/addr/len/size/burst/id/user, lock/cache/prot/qos/region)
//   w*   (valid/ready/data/strb/last/user)
//   b*   (valid/ready/resp/id/user)
//   ar*  (valid/ready/addr/len/size/burst/id/user, lock/cache/prot/qos/region)
//   r*   (valid/ready/data/resp/last/id/user)
//   Lock/cache/prot/qos/region and wuser are accepted and ignored.
// ---------------------------------------------------------------------------
module axi4_slave_mem #(
    parameter int DATA_BYTES    = 4,
    parameter int ADDR_BYTES    = 1,
    parameter int NUM_ID_BITS   = 4,
    parameter int NUM_USER_BITS = 4
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    // write address channel
    input  logic                       awvalid,
    output logic                       awready,
    input  logic [8*ADDR_BYTES-1:0]    awaddr,
    input  logic [7:0]                 awlen,
    input  logic [2:0]                 awsize,
    input  logic [1:0]                 awburst,
    input  logic [NUM_ID_BITS-1:0]     awid,
    input  logic [NUM_USER_BITS-1:0]   awuser,
    input  logic                       awlock,
    input  logic [3:0]                 awcache,
    input  logic [2:0]                 awprot,
    input  logic [3:0]                 awqos,
    input  logic [3:0]                 awregion,
    // write data channel
    input  logic                       wvalid,
    output logic                       wready,
    input  logic [8*DATA_BYTES-1:0]    wdata,
    input  logic [DATA_BYTES-1:0]      wstrb,
    input  logic                       wlast,
    input  logic [NUM_USER_BITS-1:0]   wuser,
    // write response channel
    output logic                       bvalid,
    input  logic                       bready,
    output logic [1:0]                 bresp,
    output logic [NUM_ID_BITS-1:0]     bid,
    output logic [NUM_USER_BITS-1:0]   buser,
    // read address channel
    input  logic                       arvalid,
    output logic                       arready,
    input  logic [8*ADDR_BYTES-1:0]    araddr,
    input  logic [7:0]                 arlen,
    input  logic [2:0]                 arsize,
    input  logic [1:0]                 arburst,
    input  logic [NUM_ID_BITS-1:0]     arid,
    input  logic [NUM_USER_BITS-1:0]   aruser,
    input  logic                       arlock,
    input  logic [3:0]                 arcache,
    input  logic [2:0]                 arprot,
    input  logic [3:0]                 arqos,
    input  logic [3:0]                 arregion,
    // read data channel
    output logic                       rvalid,
    input  logic                       rready,
    output logic [8*DATA_BYTES-1:0]    rdata,
    output logic [1:0]                 rresp,
    output logic                       rlast,
    output logic [NUM_ID_BITS-1:0]     rid,
    output logic [NUM_USER_BITS-1:0]   ruser
);

    localparam int DATA_W    = 8 * DATA_BYTES;
    localparam int ADDR_W    = 8 * ADDR_BYTES;
    localparam int OFF_W     = $clog2(DATA_BYTES);
    localparam int IDX_W     = ADDR_W - OFF_W;
    localparam int NUM_WORDS = 2 ** IDX_W;
    // Wide enough to hold (len+1) << size without overflow.
    localparam int WIN_W     = ADDR_W + 12;

    localparam logic [2:0] SIZE_MAX    = 3'(OFF_W);
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

    // A request is rejected with SLVERR for a reserved burst type, a beat
    // wider than the bus, or a WRAP whose length is not 2/4/8/16 beats.
    function automatic logic req_error(input logic [7:0] len,
                                       input logic [2:0] size,
                                       input logic [1:0] burst);
        logic bad_wrap_len;
        bad_wrap_len = !((len == 8'd1) || (len == 8'd3) ||
                         (len == 8'd7) || (len == 8'd15));
        return (burst == BURST_RSVD) || (size > SIZE_MAX) ||
               ((burst == BURST_WRAP) && bad_wrap_len);
    endfunction

    // Address of the next beat. WRAP keeps the upper bits of the aligned
    // window and lets only the in-window offset roll over; the window is a
    // power of two for every legal WRAP request.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                    input logic [7:0]        len,
                                                    input logic [2:0]        size,
                                                    input logic [1:0]        burst);
        logic [ADDR_W-1:0] step;
        logic [ADDR_W-1:0] mask;
        step = ADDR_W'(1) << size;
        mask = ADDR_W'((WIN_W'(len) + WIN_W'(1)) << size) - ADDR_W'(1);
        case (burst)
            BURST_FIXED: return addr;
            BURST_WRAP:  return (addr & ~mask) | ((addr + step) & mask);
            default:     return addr + step;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]     mem_q [NUM_WORDS];
    logic                  mem_we;
    logic [IDX_W-1:0]      mem_widx;

    // NOTE: the array sits behind the async reset because the block must
    // come out of reset reading all zeros; this costs a reset net per bit
    // and rules out mapping to a RAM macro, which is accepted here.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            for (int b = 0; b < DATA_BYTES; b++) begin
                if (wstrb[b]) begin
                    mem_q[mem_widx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    w_state_e                 w_state_q, w_state_d;
    logic [ADDR_W-1:0]        w_addr_q,  w_addr_d;
    logic [7:0]               w_len_q,   w_len_d;
    logic [2:0]               w_size_q,  w_size_d;
    logic [1:0]               w_burst_q, w_burst_d;
    logic [NUM_ID_BITS-1:0]   w_id_q,    w_id_d;
    logic [NUM_USER_BITS-1:0] w_user_q,  w_user_d;
    logic [7:0]               w_cnt_q,   w_cnt_d;
    logic                     w_err_q,   w_err_d;   // request-level SLVERR
    logic                     w_mis_q,   w_mis_d;   // wlast seen out of place
    logic                     awready_q, awready_d;
    logic                     wready_q,  wready_d;
    logic                     bvalid_q,  bvalid_d;
    logic [1:0]               bresp_q,   bresp_d;
    logic [NUM_ID_BITS-1:0]   bid_q,     bid_d;
    logic [NUM_USER_BITS-1:0] buser_q,   buser_d;

    logic                     w_last_beat;
    logic [ADDR_W-1:0]        w_next_addr;

    assign w_last_beat = (w_cnt_q == w_len_q);
    assign w_next_addr = next_addr(w_addr_q, w_len_q, w_size_q, w_burst_q);
    assign mem_widx    = w_addr_q[ADDR_W-1:OFF_W];

    // NOTE: every signal this block drives gets a default first, so no path
    // through the case statement leaves one unassigned and infers a latch.
    always_comb begin
        w_state_d = w_state_q;
        w_addr_d  = w_addr_q;
        w_len_d   = w_len_q;
        w_size_d  = w_size_q;
        w_burst_d = w_burst_q;
        w_id_d    = w_id_q;
        w_user_d  = w_user_q;
        w_cnt_d   = w_cnt_q;
        w_err_d   = w_err_q;
        w_mis_d   = w_mis_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        bid_d     = bid_q;
        buser_d   = buser_q;
        mem_we    = 1'b0;

        case (w_state_q)
            W_IDLE: begin
                if (awvalid && awready_q) begin
                    w_addr_d  = awaddr;
                    w_len_d   = awlen;
                    w_size_d  = awsize;
                    w_burst_d = awburst;
                    w_id_d    = awid;
                    w_user_d  = awuser;
                    w_cnt_d   = 8'd0;
                    w_err_d   = req_error(awlen, awsize, awburst);
                    w_mis_d   = 1'b0;
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    w_state_d = W_DATA;
                end
            end

            W_DATA: begin
                if (wvalid && wready_q) begin
                    mem_we  = !w_err_q;
                    w_mis_d = w_mis_q | (wlast != w_last_beat);
                    // Beat count, not wlast, ends the burst.
                    if (w_last_beat) begin
                        wready_d  = 1'b0;
                        bvalid_d  = 1'b1;
                        bresp_d   = (w_err_q || w_mis_d) ? RESP_SLVERR : RESP_OKAY;
                        bid_d     = w_id_q;
                        buser_d   = w_user_q;
                        w_state_d = W_RESP;
                    end else begin
                        w_addr_d = w_next_addr;
                        w_cnt_d  = w_cnt_q + 8'd1;
                    end
                end
            end

            W_RESP: begin
                if (bready) begin
                    bvalid_d  = 1'b0;
                    bresp_d   = RESP_OKAY;
                    awready_d = 1'b1;
                    w_state_d = W_IDLE;
                end
            end

            default: begin
                awready_d = 1'b1;
                wready_d  = 1'b0;
                bvalid_d  = 1'b0;
                w_state_d = W_IDLE;
            end
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of block order.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state_q <= W_IDLE;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_size_q  <= '0;
            w_burst_q <= '0;
            w_id_q    <= '0;
            w_user_q  <= '0;
            w_cnt_q   <= '0;
            w_err_q   <= 1'b0;
            w_mis_q   <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            bid_q     <= '0;
            buser_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_size_q  <= w_size_d;
            w_burst_q <= w_burst_d;
            w_id_q    <= w_id_d;
            w_user_q  <= w_user_d;
            w_cnt_q   <= w_cnt_d;
            w_err_q   <= w_err_d;
            w_mis_q   <= w_mis_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            bid_q     <= bid_d;
            buser_q   <= buser_d;
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    // Each beat's word is captured into rdata_q when the beat becomes
    // current, so the data holds steady under backpressure and a write
    // landing on the same edge is seen only by later beats.
    r_state_e                 r_state_q, r_state_d;
    logic [ADDR_W-1:0]        r_addr_q,  r_addr_d;
    logic [7:0]               r_len_q,   r_len_d;
    logic [2:0]               r_size_q,  r_size_d;
    logic [1:0]               r_burst_q, r_burst_d;
    logic [7:0]               r_cnt_q,   r_cnt_d;
    logic                     r_err_q,   r_err_d;
    logic                     arready_q, arready_d;
    logic                     rvalid_q,  rvalid_d;
    logic [DATA_W-1:0]        rdata_q,   rdata_d;
    logic [1:0]               rresp_q,   rresp_d;
    logic                     rlast_q,   rlast_d;
    logic [NUM_ID_BITS-1:0]   rid_q,     rid_d;
    logic [NUM_USER_BITS-1:0] ruser_q,   ruser_d;

    logic                     r_req_err;
    logic [ADDR_W-1:0]        r_next_addr;

    assign r_req_err   = req_error(arlen, arsize, arburst);
    assign r_next_addr = next_addr(r_addr_q, r_len_q, r_size_q, r_burst_q);

    always_comb begin
        r_state_d = r_state_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_size_d  = r_size_q;
        r_burst_d = r_burst_q;
        r_cnt_d   = r_cnt_q;
        r_err_d   = r_err_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        rid_d     = rid_q;
        ruser_d   = ruser_q;

        case (r_state_q)
            R_IDLE: begin
                if (arvalid && arready_q) begin
                    r_addr_d  = araddr;
                    r_len_d   = arlen;
                    r_size_d  = arsize;
                    r_burst_d = arburst;
                    r_cnt_d   = 8'd0;
                    r_err_d   = r_req_err;
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rdata_d   = r_req_err ? '0 : mem_q[araddr[ADDR_W-1:OFF_W]];
                    rresp_d   = r_req_err ? RESP_SLVERR : RESP_OKAY;
                    rlast_d   = (arlen == 8'd0);
                    rid_d     = arid;
                    ruser_d   = aruser;
                    r_state_d = R_DATA;
                end
            end

            R_DATA: begin
                if (rready) begin
                    if (rlast_q) begin
                        arready_d = 1'b1;
                        rvalid_d  = 1'b0;
                        rdata_d   = '0;
                        rresp_d   = RESP_OKAY;
                        rlast_d   = 1'b0;
                        r_state_d = R_IDLE;
                    end else begin
                        r_addr_d = r_next_addr;
                        r_cnt_d  = r_cnt_q + 8'd1;
                        rdata_d  = r_err_q ? '0 : mem_q[r_next_addr[ADDR_W-1:OFF_W]];
                        rlast_d  = ((r_cnt_q + 8'd1) == r_len_q);
                    end
                end
            end

            default: begin
                arready_d = 1'b1;
                rvalid_d  = 1'b0;
                rlast_d   = 1'b0;
                r_state_d = R_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state_q <= R_IDLE;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_size_q  <= '0;
            r_burst_q <= '0;
            r_cnt_q   <= '0;
            r_err_q   <= 1'b0;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            ruser_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_size_q  <= r_size_d;
            r_burst_q <= r_burst_d;
            r_cnt_q   <= r_cnt_d;
            r_err_q   <= r_err_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
            rid_q     <= rid_d;
            ruser_q   <= ruser_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign bid     = bid_q;
    assign buser   = buser_q;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rlast   = rlast_q;
    assign rid     = rid_q;
    assign ruser   = ruser_q;

    // Sideband inputs carry no meaning for this slave.
    logic unused_inputs;
    assign unused_inputs = ^{awlock, awcache, awprot, awqos, awregion, wuser,
                             arlock, arcache, arprot, arqos, arregion};

endmodule

// File: tb/tb_axi4_slave_mem.sv
// ---------------------------------------------------------------------------
// tb_axi4_slave_mem
//
// Cycle-stepped bench for axi4_slave_mem (DATA_BYTES=4, ADDR_BYTES=1).
// Each cycle, at the falling edge: the reference model absorbs the
// handshakes of the preceding rising edge, every DUT output is compared with
// the model, and new stimulus is driven. The model holds memory as a plain
// byte array and computes burst addresses with division/modulo arithmetic.
// ---------------------------------------------------------------------------
module tb_axi4_slave_mem;

    localparam int DB = 4;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        awvalid = 1'b0, awready;
    logic [7:0]  awaddr = '0, awlen = '0;
    logic [2:0]  awsize = '0;
    logic [1:0]  awburst = '0;
    logic [3:0]  awid = '0, awuser = '0;
    logic        wvalid = 1'b0, wready, wlast = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        bvalid, bready = 1'b0;
    logic [1:0]  bresp;
    logic [3:0]  bid, buser;
    logic        arvalid = 1'b0, arready;
    logic [7:0]  araddr = '0, arlen = '0;
    logic [2:0]  arsize = '0;
    logic [1:0]  arburst = '0;
    logic [3:0]  arid = '0, aruser = '0;
    logic        rvalid, rready = 1'b0, rlast;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic [3:0]  rid, ruser;

    always #5 aclk = ~aclk;

    axi4_slave_mem #(.DATA_BYTES(DB), .ADDR_BYTES(1), .NUM_ID_BITS(4), .NUM_USER_BITS(4)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
        .awsize(awsize), .awburst(awburst), .awid(awid), .awuser(awuser),
        .awlock(1'b0), .awcache(4'h0), .awprot(3'h0), .awqos(4'h0), .awregion(4'h0),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wuser(4'h0),
        .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid), .buser(buser),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst), .arid(arid), .aruser(aruser),
        .arlock(1'b0), .arcache(4'h0), .arprot(3'h0), .arqos(4'h0), .arregion(4'h0),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rid(rid), .ruser(ruser)
    );

    // Transaction descriptor. early_last: -1 = wlast on the final beat,
    // -2 = wlast never driven, k >= 0 = wlast on beat k only.
    typedef struct {
        int addr, len, size, burst, id, user;
        int strb;  bit rnd_strb;  bit rnd_valid;
        int early_last, b_delay, hold_beat, hold_cycles;
    } txn_t;

    txn_t        wq[$], rq[$];
    logic [31:0] wdq[$];          // write data, all beats in issue order
    txn_t        cur_w, cur_r;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  mmem [256];
    int          m_w_phase, m_w_addr, m_w_len, m_w_size, m_w_burst, m_w_id, m_w_user, m_w_cnt;
    bit          m_w_err, m_w_mis;
    int          m_bresp, m_last_bresp, b_wait;
    int          m_r_phase, m_r_addr, m_r_len, m_r_size, m_r_burst, m_r_id, m_r_user, m_r_cnt;
    bit          m_r_err;
    logic [31:0] m_r_data;
    int          r_hold;

    function automatic bit is_err(int burst, int size, int len);
        return burst == 3 || size > 2 ||
               (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
    endfunction

    function automatic int nxt_addr(int a, int size, int burst, int len);
        int step, win, base;
        step = 1 << size;
        if (burst == 0) return a;
        if (burst == 2) begin
            win  = (len + 1) * step;
            base = (a / win) * win;
            return (base + (a - base + step) % win) % 256;
        end
        return (a + step) % 256;
    endfunction

    function automatic logic [31:0] m_word(int a);
        logic [31:0] w;
        int base;
        base = (a / DB) * DB;
        for (int b = 0; b < DB; b++) w[8*b +: 8] = mmem[base + b];
        return w;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 256; i++) mmem[i] = 8'h00;
        m_w_phase = 0; m_r_phase = 0; m_w_cnt = 0; m_r_cnt = 0;
        wq.delete(); rq.delete(); wdq.delete();
    endfunction

    // Absorb the handshakes of the last rising edge. The read side goes
    // first so that a beat fetched on the same edge as a write sees the
    // memory contents from before that write.
    task automatic model_update();
        if (m_r_phase == 0) begin
            if (arvalid) begin
                cur_r     = rq.pop_front();
                m_r_addr  = int'(araddr); m_r_len = int'(arlen); m_r_size = int'(arsize);
                m_r_burst = int'(arburst); m_r_id = int'(arid); m_r_user = int'(aruser);
                m_r_cnt   = 0; r_hold = 0;
                m_r_err   = is_err(m_r_burst, m_r_size, m_r_len);
                m_r_data  = m_r_err ? 32'h0 : m_word(m_r_addr);
                m_r_phase = 1;
            end
        end else if (rready) begin
            if (m_r_cnt == m_r_len) m_r_phase = 0;
            else begin
                m_r_addr = nxt_addr(m_r_addr, m_r_size, m_r_burst, m_r_len);
                m_r_cnt++;
                m_r_data = m_r_err ? 32'h0 : m_word(m_r_addr);
            end
        end

        if (m_w_phase == 0) begin
            if (awvalid) begin
                cur_w     = wq.pop_front();
                m_w_addr  = int'(awaddr); m_w_len = int'(awlen); m_w_size = int'(awsize);
                m_w_burst = int'(awburst); m_w_id = int'(awid); m_w_user = int'(awuser);
                m_w_cnt   = 0; m_w_mis = 0;
                m_w_err   = is_err(m_w_burst, m_w_size, m_w_len);
                m_w_phase = 1;
            end
        end else if (m_w_phase == 1) begin
            if (wvalid) begin
                if (!m_w_err)
                    for (int b = 0; b < DB; b++)
                        if (wstrb[b]) mmem[(m_w_addr / DB) * DB + b] = wdata[8*b +: 8];
                if (wlast != (m_w_cnt == m_w_len)) m_w_mis = 1;
                void'(wdq.pop_front());
                if (m_w_cnt == m_w_len) begin
                    m_bresp      = (m_w_err || m_w_mis) ? 2 : 0;
                    m_last_bresp = m_bresp;
                    b_wait       = 0;
                    m_w_phase    = 2;
                end else begin
                    m_w_addr = nxt_addr(m_w_addr, m_w_size, m_w_burst, m_w_len);
                    m_w_cnt++;
                end
            end
        end else if (bready) begin
            m_w_phase = 0;
        end
    endtask

    task automatic compare();
        check("awready", awready, m_w_phase == 0);
        check("wready",  wready,  m_w_phase == 1);
        check("bvalid",  bvalid,  m_w_phase == 2);
        if (m_w_phase == 2) begin
            check("bresp", bresp, m_bresp);
            check("bid",   bid,   m_w_id);
            check("buser", buser, m_w_user);
        end
        check("arready", arready, m_r_phase == 0);
        check("rvalid",  rvalid,  m_r_phase == 1);
        if (m_r_phase == 1) begin
            check("rdata", rdata, m_r_data);
            check("rlast", rlast, m_r_cnt == m_r_len);
            check("rresp", rresp, m_r_err ? 2 : 0);
            check("rid",   rid,   m_r_id);
            check("ruser", ruser, m_r_user);
        end
    endtask

    task automatic drive();
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        if (m_w_phase == 0) begin
            if (wq.size() > 0 && $urandom_range(0, 3) != 0) begin
                awvalid = 1'b1;
                awaddr = 8'(wq[0].addr); awlen = 8'(wq[0].len); awsize = 3'(wq[0].size);
                awburst = 2'(wq[0].burst); awid = 4'(wq[0].id); awuser = 4'(wq[0].user);
            end
        end else if (m_w_phase == 1) begin
            wvalid = cur_w.rnd_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
            wdata  = (wdq.size() > 0) ? wdq[0] : 32'h0;
            wstrb  = cur_w.rnd_strb ? 4'($urandom) : 4'(cur_w.strb);
            if (cur_w.early_last == -1)      wlast = (m_w_cnt == m_w_len);
            else if (cur_w.early_last == -2) wlast = 1'b0;
            else                             wlast = (m_w_cnt == cur_w.early_last);
        end else begin
            if (b_wait < cur_w.b_delay) b_wait++;
            else bready = 1'b1;
        end

        if (m_r_phase == 0) begin
            if (rq.size() > 0 && $urandom_range(0, 3) != 0) begin
                arvalid = 1'b1;
                araddr = 8'(rq[0].addr); arlen = 8'(rq[0].len); arsize = 3'(rq[0].size);
                arburst = 2'(rq[0].burst); arid = 4'(rq[0].id); aruser = 4'(rq[0].user);
            end
        end else begin
            if (m_r_cnt == cur_r.hold_beat && r_hold < cur_r.hold_cycles) begin
                r_hold++;
                rready = 1'b0;
            end else begin
                rready = cur_r.rnd_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end
    endtask

    task automatic step_cycle();
        @(negedge aclk);
        model_update();
        compare();
        drive();
    endtask

    task automatic run_until_idle(input string name, input int budget);
        int n = 0;
        while ((wq.size() > 0 || rq.size() > 0 || m_w_phase != 0 || m_r_phase != 0) && n < budget) begin
            step_cycle();
            n++;
        end
        check({name, "_completed"}, n < budget, 1'b1);
        step_cycle();
        step_cycle();
    endtask

    task automatic do_reset();
        @(negedge aclk);
        aresetn = 1'b0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0; wlast = 1'b0;
        model_reset();
        #100;
        check("rst_awready", awready, 1'b1);
        check("rst_arready", arready, 1'b1);
        check("rst_wready",  wready,  1'b0);
        check("rst_bvalid",  bvalid,  1'b0);
        check("rst_rvalid",  rvalid,  1'b0);
        check("rst_outs", {bresp, bid, buser, rdata, rresp, rlast, rid, ruser}, 64'h0);
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    function automatic txn_t mk(int addr, int len, int size, int burst, int id, int user);
        txn_t t;
        t.addr = addr; t.len = len; t.size = size; t.burst = burst; t.id = id; t.user = user;
        t.strb = 4'hF; t.rnd_strb = 0; t.rnd_valid = 0; t.early_last = -1;
        t.b_delay = 0; t.hold_beat = 0; t.hold_cycles = 0;
        return t;
    endfunction

    function automatic txn_t mk_rand();
        txn_t t;
        int   x;
        x = $urandom_range(0, 9);
        t = mk($urandom_range(0, 255), 0, 0, 0, $urandom_range(0, 15), $urandom_range(0, 15));
        t.burst = (x < 1) ? 3 : (x < 4) ? 0 : (x < 7) ? 1 : 2;
        t.size  = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
        if (t.burst == 2) begin
            x = $urandom_range(0, 4);
            t.len = (x == 0) ? 1 : (x == 1) ? 3 : (x == 2) ? 7 : (x == 3) ? 15 : 2;
        end else t.len = $urandom_range(0, 7);
        t.rnd_strb = 1; t.rnd_valid = 1; t.b_delay = $urandom_range(0, 3);
        x = $urandom_range(0, 19);
        if (x < 2 && t.len > 0) t.early_last = $urandom_range(0, t.len - 1);
        else if (x == 2)        t.early_last = -2;
        return t;
    endfunction

    task automatic push_rand_data(input int beats);
        for (int i = 0; i < beats; i++) wdq.push_back($urandom);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t t;

        // Model self-checks against hand-computed values.
        check("pin_wrap_next",  nxt_addr(12, 2, 2, 3), 0);
        check("pin_wrap_mid",   nxt_addr(8, 2, 2, 3), 12);
        check("pin_incr_roll",  nxt_addr(252, 2, 1, 0), 0);
        check("pin_fixed",      nxt_addr(4, 2, 0, 1), 4);
        check("pin_err_wrap2",  is_err(2, 2, 2), 1'b1);
        check("pin_err_size3",  is_err(1, 3, 0), 1'b1);
        check("pin_ok_wrap7",   is_err(2, 1, 7), 1'b0);

        do_reset();

        // Memory reads zero after reset.
        rq.push_back(mk(8'h30, 0, 2, 1, 3, 5));
        rq.push_back(mk(8'hC4, 3, 2, 1, 4, 6));
        run_until_idle("rst_read", 100);

        // 10-beat INCR write, bready held off 5 cycles.
        t = mk(0, 9, 2, 1, 0, 2); t.b_delay = 5;
        wq.push_back(t); push_rand_data(10);
        run_until_idle("incr_write", 200);
        check("pin_incr_bresp", m_last_bresp, 0);

        // Read it back with a 5-cycle stall mid-burst, then the top word.
        t = mk(0, 9, 2, 1, 7, 1); t.hold_beat = 4; t.hold_cycles = 5;
        rq.push_back(t);
        rq.push_back(mk(8'hFF, 0, 2, 1, 9, 3));
        run_until_idle("incr_read", 200);
        check("pin_word63", m_word(8'hFF), 32'h0);

        // WRAP write A,B,C,D from 0x08; FIXED read at 0x04 returns D twice.
        wq.push_back(mk(8'h08, 3, 2, 2, 5, 0));
        wdq.push_back(32'hAAAA_0001); wdq.push_back(32'hBBBB_0002);
        wdq.push_back(32'hCCCC_0003); wdq.push_back(32'hDDDD_0004);
        run_until_idle("wrap_write", 100);
        check("pin_wrap_08", m_word(8'h08), 32'hAAAA_0001);
        check("pin_wrap_0c", m_word(8'h0C), 32'hBBBB_0002);
        check("pin_wrap_00", m_word(8'h00), 32'hCCCC_0003);
        check("pin_wrap_04", m_word(8'h04), 32'hDDDD_0004);
        rq.push_back(mk(8'h04, 1, 2, 0, 2, 2));
        rq.push_back(mk(8'h08, 3, 2, 2, 3, 3));
        run_until_idle("wrap_read", 100);

        // Byte strobes, reserved burst, early wlast, bad WRAP length.
        wq.push_back(mk(8'h40, 0, 2, 1, 1, 1)); wdq.push_back(32'hAABB_CCDD);
        t = mk(8'h42, 0, 2, 1, 1, 1); t.strb = 4'h3;
        wq.push_back(t); wdq.push_back(32'h1122_3344);
        run_until_idle("strb_write", 100);
        check("pin_strb", m_word(8'h40), 32'hAABB_3344);
        wq.push_back(mk(8'h40, 0, 2, 3, 6, 6)); wdq.push_back(32'hDEAD_BEEF);
        run_until_idle("rsvd_write", 100);
        check("pin_rsvd_bresp", m_last_bresp, 2);
        check("pin_rsvd_mem", m_word(8'h40), 32'hAABB_3344);
        t = mk(8'h80, 3, 2, 1, 8, 8); t.early_last = 1;
        wq.push_back(t); push_rand_data(4);
        run_until_idle("early_last", 100);
        check("pin_early_bresp", m_last_bresp, 2);
        wq.push_back(mk(8'h90, 2, 2, 2, 2, 2)); push_rand_data(3);
        rq.push_back(mk(8'h40, 0, 2, 1, 1, 1));
        rq.push_back(mk(8'h40, 1, 2, 3, 2, 2));
        rq.push_back(mk(8'h80, 3, 2, 1, 3, 3));
        rq.push_back(mk(8'h90, 2, 2, 2, 4, 4));
        run_until_idle("err_mix", 200);
        check("pin_badwrap_bresp", m_last_bresp, 2);

        // Concurrent random traffic.
        for (int i = 0; i < 60; i++) begin
            t = mk_rand(); wq.push_back(t); push_rand_data(t.len + 1);
            rq.push_back(mk_rand());
        end
        run_until_idle("random", 20000);

        // Reset in the middle of a long write: nothing survives.
        t = mk(8'h00, 15, 2, 1, 1, 1);
        wq.push_back(t); push_rand_data(16);
        for (int i = 0; i < 8; i++) step_cycle();
        do_reset();
        rq.push_back(mk(8'h00, 15, 2, 1, 5, 5));
        rq.push_back(mk(8'h80, 3, 2, 1, 6, 6));
        run_until_idle("post_reset_read", 200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
